hand_datapath: RTL

//  Card-holding datapath for the baccarat game. Holds six card registers: player 1-3 and dealer 1-3.

---
 rtl/baccarat_pkg.sv | 20 ++
 rtl/hand_datapath_if.sv | 41 ++++
 rtl/deal_counter.sv | 35 +++
 rtl/hand_datapath.sv | 102 ++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared baccarat types, card constants and the card-to-value mapping.
// Used by hand_datapath and the dealing state machine.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_TEN   = 4'd10;
    localparam card_t CARD_KING  = 4'd13;

    // Ace..9 score face value; tens, court cards, empty slots and illegal codes score 0.
    function automatic logic [3:0] card_value(card_t card);
        if (card >= CARD_ACE && card < CARD_TEN) begin
            return card;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/hand_datapath_if.sv
// Bus between the dealing state machine (master) and hand_datapath (slave):
// card source, load strobes, card registers, scores and sticky error flags.
interface hand_datapath_if #(
    parameter int unsigned CARD_W = 4
);
    logic [CARD_W-1:0] new_card;
    logic              load_pcard1;
    logic              load_pcard2;
    logic              load_pcard3;
    logic              load_dcard1;
    logic              load_dcard2;
    logic              load_dcard3;
    logic [CARD_W-1:0] pcard1;
    logic [CARD_W-1:0] pcard2;
    logic [CARD_W-1:0] pcard3;
    logic [CARD_W-1:0] dcard1;
    logic [CARD_W-1:0] dcard2;
    logic [CARD_W-1:0] dcard3;
    logic [3:0]        pscore;
    logic [3:0]        dscore;
    logic [3:0]        pcard3_val;
    logic              bad_card;
    logic              multi_load;

    modport master (
        output new_card,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        input  pscore, dscore, pcard3_val, bad_card, multi_load
    );

    modport slave (
        input  new_card,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        output pscore, dscore, pcard3_val, bad_card, multi_load
    );

endinterface

// File: rtl/deal_counter.sv
// Wrapping 1..NUM_RANKS card counter, advancing every clock; async active-low reset to 1.
// Only instantiated when DEAL_COUNTER_EN is defined.
module deal_counter #(
    parameter int unsigned CARD_W    = 4,
    parameter int unsigned NUM_RANKS = 13
) (
    input  logic              slow_clock,
    input  logic              resetb,
    output logic [CARD_W-1:0] count
);

    localparam logic [CARD_W-1:0] FirstCard = CARD_W'(1);
    localparam logic [CARD_W-1:0] LastCard  = CARD_W'(NUM_RANKS);

    logic [CARD_W-1:0] count_q;
    logic [CARD_W-1:0] count_d;

    always_comb begin
        count_d = count_q + FirstCard;
        if (count_q == LastCard) begin
            count_d = FirstCard;
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            count_q <= FirstCard;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hand_datapath.sv
// Baccarat card-holding datapath: six card registers, combinational hand scores, sticky flags.
// Build option DEAL_COUNTER_EN sources cards from an internal deal_counter instead of new_card.
module hand_datapath
    import baccarat_pkg::*;
#(
    parameter int unsigned CARD_W    = 4,
    parameter int unsigned NUM_RANKS = 13
) (
    input  logic           slow_clock,
    input  logic           resetb,
    hand_datapath_if.slave hand
);

    localparam logic [CARD_W-1:0] MaxCard = CARD_W'(NUM_RANKS);

    logic [CARD_W-1:0] src_card;
    logic [5:0]        load_vec;
    logic              card_legal;
    logic              any_load;
    logic              many_load;
    logic [CARD_W-1:0] card_q [6];
    logic              bad_q;
    logic              multi_q;
    logic [4:0]        psum;
    logic [4:0]        dsum;

`ifdef DEAL_COUNTER_EN
    logic unused_new_card;

    deal_counter #(
        .CARD_W    (CARD_W),
        .NUM_RANKS (NUM_RANKS)
    ) u_deal_counter (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .count      (src_card)
    );

    assign unused_new_card = ^hand.new_card;
`else
    assign src_card = hand.new_card;
`endif

    // Index order 0..2 = player 1..3, 3..5 = dealer 1..3.
    assign load_vec = {hand.load_dcard3, hand.load_dcard2, hand.load_dcard1,
                       hand.load_pcard3, hand.load_pcard2, hand.load_pcard1};

    assign card_legal = (src_card != '0) && (src_card <= MaxCard);
    assign any_load   = |load_vec;
    assign many_load  = |(load_vec & (load_vec - 6'd1));

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 6; i++) begin
                card_q[i] <= CARD_W'(CARD_EMPTY);
            end
            bad_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (load_vec[i] && card_legal) begin
                    card_q[i] <= src_card;
                end
            end
            if (any_load && !card_legal) begin
                bad_q <= 1'b1;
            end
            if (many_load) begin
                multi_q <= 1'b1;
            end
        end
    end

    function automatic logic [3:0] mod10(logic [4:0] sum);
        if (sum >= 5'd20) begin
            return 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            return 4'(sum - 5'd10);
        end
        return sum[3:0];
    endfunction

    always_comb begin
        psum = 5'(card_value(card_t'(card_q[0]))) + 5'(card_value(card_t'(card_q[1])))
             + 5'(card_value(card_t'(card_q[2])));
        dsum = 5'(card_value(card_t'(card_q[3]))) + 5'(card_value(card_t'(card_q[4])))
             + 5'(card_value(card_t'(card_q[5])));
    end

    assign hand.pcard1     = card_q[0];
    assign hand.pcard2     = card_q[1];
    assign hand.pcard3     = card_q[2];
    assign hand.dcard1     = card_q[3];
    assign hand.dcard2     = card_q[4];
    assign hand.dcard3     = card_q[5];
    assign hand.pscore     = mod10(psum);
    assign hand.dscore     = mod10(dsum);
    assign hand.pcard3_val = card_value(card_t'(card_q[2]));
    assign hand.bad_card   = bad_q;
    assign hand.multi_load = multi_q;

endmodule
